// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int          REG_W     = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic main_stall;
    logic flush_ifid;
    logic stall_mem_stall;
  } ctrl_t;

  // Canonical output sets: idle, memory freeze, branch bubble, load-use bubble.
  localparam ctrl_t CTRL_IDLE   = 7'b1111_000;
  localparam ctrl_t CTRL_FREEZE = 7'b0000_001;
  localparam ctrl_t CTRL_FLUSH  = 7'b1111_110;
  localparam ctrl_t CTRL_HAZ    = 7'b0011_100;
endpackage

// File: rtl/raw_match.sv
// One in-flight destination compared against the decode-stage sources.
module raw_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] dest,
  input  logic             wr,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             reading_rs,
  input  logic             reading_rt,
  output logic             hit
);
  assign hit = wr & ((reading_rs & (dest == rs)) | (reading_rt & (dest == rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: latch enables, bubble insert and replay hold.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FORWARDING     = 1,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reading_rs,
  input  logic             id_reading_rt,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] mem_dest,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             branch_taken,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             main_stall,
  output logic             flush_ifid,
  output logic             stall_mem_stall,
  output logic [15:0]      stall_count
);
  localparam int NSRC = (FORWARDING != 0) ? 1 : 3;

  logic [NSRC-1:0] src_hit;
  logic            data_hazard;
  logic            unused_in;

  // Not every configuration consumes every writer input.
  assign unused_in = ^{mem_dest, wb_dest, mem_regwrite, wb_regwrite, ex_memtoreg};

  generate
    if (FORWARDING != 0) begin : g_fwd
      // Only a load in EX cannot be forwarded in time.
      raw_match u_ex (
        .dest(ex_dest), .wr(ex_regwrite & ex_memtoreg),
        .rs(id_rs), .rt(id_rt),
        .reading_rs(id_reading_rs), .reading_rt(id_reading_rt),
        .hit(src_hit[0])
      );
    end else begin : g_nofwd
      logic [2:0][REG_W-1:0] dst;
      logic [2:0]            wr;
      assign dst = {wb_dest, mem_dest, ex_dest};
      assign wr  = {wb_regwrite, mem_regwrite, ex_regwrite};
      for (genvar i = 0; i < 3; i++) begin : g_src
        raw_match u_m (
          .dest(dst[i]), .wr(wr[i]),
          .rs(id_rs), .rt(id_rt),
          .reading_rs(id_reading_rs), .reading_rt(id_reading_rt),
          .hit(src_hit[i])
        );
      end
    end
  endgenerate

  assign data_hazard = id_valid & (|src_hit);

  state_e      state, state_nxt;
  logic [1:0]  flush_cnt, cnt_nxt;
  ctrl_t       ctrl;
  logic        stall_any;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = flush_cnt;
    ctrl      = CTRL_IDLE;
    case (state)
      RUN: begin
        if (dmem_stall) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
        end else if (branch_taken) begin
          ctrl      = CTRL_FLUSH;
          cnt_nxt   = 2'(BRANCH_PENALTY - 1);
          state_nxt = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
        end else if (data_hazard) begin
          ctrl = CTRL_HAZ;
        end
      end
      MEM_WAIT: begin
        // Release is combinational on the done cycle; leftover bubbles resume after.
        if (dmem_done) state_nxt = (flush_cnt != 2'd0) ? FLUSH : RUN;
        else           ctrl      = CTRL_FREEZE;
      end
      FLUSH: begin
        if (dmem_stall) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = MEM_WAIT;
        end else begin
          ctrl    = CTRL_FLUSH;
          cnt_nxt = flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst) ctrl = CTRL_IDLE;
  end

  assign stall_any = ctrl.main_stall | ctrl.flush_ifid | ctrl.stall_mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      flush_cnt   <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= cnt_nxt;
      if (stall_any && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

  assign pc_en           = ctrl.pc_en;
  assign ifid_en         = ctrl.ifid_en;
  assign idex_en         = ctrl.idex_en;
  assign exmem_en        = ctrl.exmem_en;
  assign main_stall      = ctrl.main_stall;
  assign flush_ifid      = ctrl.flush_ifid;
  assign stall_mem_stall = ctrl.stall_mem_stall;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controller configurations on shared stimulus against a bubble-count model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_reading_rs, id_reading_rt;
  logic [2:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
  logic branch_taken, dmem_stall, dmem_done;

  logic a_pc, a_ifid, a_idex, a_exmem, a_ms, a_fl, a_sms;
  logic b_pc, b_ifid, b_idex, b_exmem, b_ms, b_fl, b_sms;
  logic [15:0] a_cnt, b_cnt;
  logic [6:0] a_vec, b_vec;
  assign a_vec = {a_pc, a_ifid, a_idex, a_exmem, a_ms, a_fl, a_sms};
  assign b_vec = {b_pc, b_ifid, b_idex, b_exmem, b_ms, b_fl, b_sms};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARDING(1), .BRANCH_PENALTY(2)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_reading_rs(id_reading_rs), .id_reading_rt(id_reading_rt),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem),
    .main_stall(a_ms), .flush_ifid(a_fl), .stall_mem_stall(a_sms), .stall_count(a_cnt));

  pipe_hazard_ctrl #(.FORWARDING(0), .BRANCH_PENALTY(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_reading_rs(id_reading_rs), .id_reading_rt(id_reading_rt),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem),
    .main_stall(b_ms), .flush_ifid(b_fl), .stall_mem_stall(b_sms), .stall_count(b_cnt));

  // Output sets ordered {pc, ifid, idex, exmem, main_stall, flush_ifid, stall_mem_stall}.
  localparam logic [6:0] O_IDLE = 7'b1111000, O_FREEZE = 7'b0000001,
                         O_FLUSH = 7'b1111110, O_HAZ = 7'b0011100;
  localparam int FW_P[2] = '{1, 0};
  localparam int BP_P[2] = '{2, 3};

  int checks = 0, failures = 0;
  bit mem_wait[2];
  int flush_left[2];
  int cnt[2];

  function automatic logic [6:0] obs(int k);
    return (k == 0) ? a_vec : b_vec;
  endfunction

  function automatic logic [15:0] obs_cnt(int k);
    return (k == 0) ? a_cnt : b_cnt;
  endfunction

  function automatic bit reads(logic [2:0] d);
    return (id_reading_rs && d == id_rs) || (id_reading_rt && d == id_rt);
  endfunction

  function automatic bit hazard(int k);
    if (!id_valid) return 1'b0;
    if (FW_P[k] != 0) return ex_regwrite && ex_memtoreg && reads(ex_dest);
    return (ex_regwrite && reads(ex_dest)) || (mem_regwrite && reads(mem_dest)) ||
           (wb_regwrite && reads(wb_dest));
  endfunction

  // Model: a memory wait flag plus the number of branch bubbles still owed.
  task automatic model_eval(input int k, output logic [6:0] o, output bit nmw, output int nfl);
    nmw = mem_wait[k];
    nfl = flush_left[k];
    if (mem_wait[k]) begin
      if (dmem_done) begin o = O_IDLE; nmw = 1'b0; end
      else o = O_FREEZE;
    end else if (dmem_stall) begin
      o = O_FREEZE; nmw = 1'b1;
    end else if (flush_left[k] > 0) begin
      o = O_FLUSH; nfl = flush_left[k] - 1;
    end else if (branch_taken) begin
      o = O_FLUSH; nfl = BP_P[k] - 1;
    end else if (hazard(k)) o = O_HAZ;
    else o = O_IDLE;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mem_wait[k] = 1'b0; flush_left[k] = 0; cnt[k] = 0;
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_reading_rs = 0; id_reading_rt = 0;
    ex_dest = 0; ex_regwrite = 0; ex_memtoreg = 0; mem_dest = 0; wb_dest = 0;
    mem_regwrite = 0; wb_regwrite = 0; branch_taken = 0; dmem_stall = 0; dmem_done = 0;
  endtask

  // Called at a negedge with inputs set: check, clock, advance model.
  task automatic tick(input string nm);
    logic [6:0] o[2];
    bit nmw[2];
    int nfl[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, o[k], nmw[k], nfl[k]);
      checks++;
      if (obs(k) !== o[k]) begin
        failures++;
        $display("FAIL %s dut%0d outputs got %b want %b", nm, k, obs(k), o[k]);
      end
      checks++;
      if (obs_cnt(k) !== 16'(cnt[k])) begin
        failures++;
        $display("FAIL %s dut%0d stall_count got %0d want %0d", nm, k, obs_cnt(k), cnt[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mem_wait[k]   = nmw[k];
      flush_left[k] = nfl[k];
      if ((|o[k][2:0]) && cnt[k] < 65535) cnt[k]++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    dmem_stall = 1; branch_taken = 1; id_valid = 1; ex_regwrite = 1; ex_memtoreg = 1;
    id_reading_rs = 1;
    #2;
    checks++;
    if (a_vec !== O_IDLE || b_vec !== O_IDLE) begin
      failures++;
      $display("FAIL reset_outputs got %b/%b want %b", a_vec, b_vec, O_IDLE);
    end
    checks++;
    if (a_cnt !== 16'd0 || b_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got %0d/%0d want 0", a_cnt, b_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    tick("reset_idle");
  endtask

  task automatic test_load_use();
    ex_memtoreg = 1; ex_regwrite = 1; ex_dest = 3; id_rs = 3; id_reading_rs = 1; id_valid = 1;
    #1;
    checks++;
    if ({a_pc, a_ifid, a_ms} !== 3'b001) begin
      failures++;
      $display("FAIL load_use_direct got %b want 001", {a_pc, a_ifid, a_ms});
    end
    tick("load_use");
    clear_inputs();
    tick("load_use_after");
    checks++;
    if (a_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_count got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_branch();
    branch_taken = 1;
    tick("branch");
    branch_taken = 0;
    repeat (4) tick("branch_tail");
  endtask

  task automatic test_mem_stall();
    dmem_stall = 1;
    repeat (3) tick("mem_stall");
    dmem_done = 1;
    #1;
    checks++;
    if ({a_pc, a_ifid, a_idex, a_exmem, a_sms} !== 5'b11110) begin
      failures++;
      $display("FAIL mem_release got %b want 11110", {a_pc, a_ifid, a_idex, a_exmem, a_sms});
    end
    tick("mem_done");
    clear_inputs();
    repeat (2) tick("mem_tail");
  endtask

  task automatic test_mem_in_flush();
    branch_taken = 1;
    tick("mif_branch");
    branch_taken = 0;
    dmem_stall = 1;
    repeat (2) tick("mif_wait");
    dmem_done = 1;
    tick("mif_done");
    clear_inputs();
    repeat (4) tick("mif_resume");
  endtask

  task automatic test_forwarding();
    mem_regwrite = 1; mem_dest = 5; id_rt = 5; id_reading_rt = 1; id_valid = 1;
    #1;
    checks++;
    if (a_ms !== 1'b0 || b_ms !== 1'b1) begin
      failures++;
      $display("FAIL fwd_select got fw1=%b fw0=%b want fw1=0 fw0=1", a_ms, b_ms);
    end
    tick("fwd");
    clear_inputs();
    tick("fwd_after");
  endtask

  task automatic test_reset_mid();
    dmem_stall = 1;
    repeat (2) tick("rmid_wait");
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_vec !== O_IDLE || b_vec !== O_IDLE || a_cnt !== 16'd0 || b_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got %b/%b cnt %0d/%0d want %b cnt 0", a_vec, b_vec, a_cnt, b_cnt, O_IDLE);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick("reset_mid_run");
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs         = 3'($urandom_range(0, 7));
      id_rt         = 3'($urandom_range(0, 7));
      id_reading_rs = 1'($urandom_range(0, 1));
      id_reading_rt = 1'($urandom_range(0, 1));
      ex_dest       = 3'($urandom_range(0, 7));
      mem_dest      = 3'($urandom_range(0, 7));
      wb_dest       = 3'($urandom_range(0, 7));
      ex_regwrite   = 1'($urandom_range(0, 1));
      ex_memtoreg   = 1'($urandom_range(0, 1));
      mem_regwrite  = 1'($urandom_range(0, 1));
      wb_regwrite   = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 7) == 0);
      dmem_stall    = ($urandom_range(0, 11) == 0);
      dmem_done     = ($urandom_range(0, 2) == 0);
      tick("random");
    end
    clear_inputs();
    repeat (4) tick("random_drain");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_mem_in_flush();
    test_forwarding();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; the producer side of the stall controls that the pipeline latches consume.
- Generates the bubble-insert (`main_stall`), replay-hold (`stall_mem_stall`) and per-latch enable signals from decode-stage register reads, in-flight destinations, resolved branches and data-memory busy.
- Sits beside the decode stage; its outputs fan out to PC, IF/ID, ID/EX and EX/MEM.

Parameters:
- FORWARDING, 1: 1 = stall only on load-use; 0 = stall on any RAW against EX, MEM or WB.
- BRANCH_PENALTY, 2: bubble cycles inserted per taken branch/jump; legal range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  3 each  decode source registers
- id_reading_rs, id_reading_rt  in  1 each  source actually read
- ex_dest  in  3  ID/EX destination register
- ex_regwrite, ex_memtoreg  in  1 each  ID/EX writes reg / is load
- mem_dest, wb_dest  in  3 each  EX/MEM, MEM/WB destination
- mem_regwrite, wb_regwrite  in  1 each  matching write enables
- branch_taken  in  1  EX resolved taken branch/jump (BranchingOrJumping qualified)
- dmem_stall  in  1  data memory busy
- dmem_done  in  1  data memory access complete
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  latch write enables
- main_stall  out  1  inject NOP (16'h0800) and zeroed controls into ID/EX
- flush_ifid  out  1  replace IF/ID with NOP
- stall_mem_stall  out  1  ID/EX recirculates current contents
- stall_count  out  16  saturating count of cycles with any stall/flush active

Behaviour:
- Reset (rst=0, async):
  - state=RUN, flush_cnt=0, stall_count=0.
  - All outputs forced to the inactive set: enables=1, main_stall=0, flush_ifid=0, stall_mem_stall=0.
- Outputs are combinational from state plus inputs. No added latency: a hazard visible in cycle N gates the latch writes at the end of cycle N.
- States: RUN, MEM_WAIT, FLUSH. Priority when several conditions hold in one cycle: memory stall > branch flush > data hazard.
- RUN:
  - dmem_stall=1: all enables=0, stall_mem_stall=1; next=MEM_WAIT.
  - else branch_taken=1: flush_ifid=1, main_stall=1, enables=1; flush_cnt<=BRANCH_PENALTY-1; next=FLUSH if BRANCH_PENALTY>1, else RUN.
  - else data hazard: pc_en=0, ifid_en=0, main_stall=1, idex_en=exmem_en=1 for that cycle; stays RUN.
  - else: all enables=1, nothing asserted.
- Data hazard definition:
  - Requires id_valid and a source match with a read flag set, i.e. (id_reading_rs & src==id_rs) | (id_reading_rt & src==id_rt).
  - FORWARDING=1: src=ex_dest, qualified by ex_regwrite&ex_memtoreg.
  - FORWARDING=0: additionally ex_dest/ex_regwrite (any writer), mem_dest/mem_regwrite and wb_dest/wb_regwrite.
  - Register 0 is not special (r0 is a real register).
- MEM_WAIT:
  - Frozen: all enables=0, stall_mem_stall=1, until dmem_done=1.
  - On the dmem_done cycle the freeze drops combinationally (enables=1). Next=FLUSH if flush_cnt!=0, else RUN.
  - branch_taken is ignored in MEM_WAIT. EX is frozen, so the branch is re-seen after release.
- FLUSH:
  - flush_ifid=1, main_stall=1, enables=1; flush_cnt decrements; at flush_cnt==1 next=RUN.
  - dmem_stall has priority: go to MEM_WAIT with flush_cnt held, then resume FLUSH.
  - A data hazard in FLUSH is ignored (IF/ID is being flushed anyway).
  - branch_taken in FLUSH is ignored (it is a bubble).
- stall_count increments each cycle in which any of main_stall, flush_ifid or stall_mem_stall is 1; saturates at 16'hFFFF.
- dmem_done without a prior dmem_stall (in RUN) is ignored.
- Reset asserted mid-MEM_WAIT or mid-FLUSH immediately returns to RUN with counters cleared.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR=16'h0800.
  - State encoding constants (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2).
  - Register-index width (3).
- One natural sub-module, raw_match: a combinational comparator of one destination against rs/rt with read and write qualifiers. Instantiated 1 or 3 times depending on FORWARDING.
- The FSM, flush counter and stall counter stay in the top module.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_dest=3, id_rs=3, id_reading_rs=1 -> exactly one cycle of pc_en=0, ifid_en=0, main_stall=1; stall_count=1.
- Taken branch, BRANCH_PENALTY=2: branch_taken pulse -> flush_ifid=main_stall=1 for 2 consecutive cycles, then RUN; stall_count=2.
- Memory stall: dmem_stall=1 for 4 cycles, dmem_done on the 4th -> all enables=0 and stall_mem_stall=1 for cycles 1-3; enables=1 on cycle 4.
- Memory stall during FLUSH: dmem_stall arrives on flush cycle 1 -> MEM_WAIT; after dmem_done, 1 remaining flush cycle is issued, then RUN.
- FORWARDING=0: mem_regwrite=1, mem_dest=5, id_rt=5, id_reading_rt=1 -> stall asserted; same stimulus with FORWARDING=1 -> no stall.
- Reset mid-MEM_WAIT: rst=0 -> outputs go inactive immediately and stall_count=0; after rst=1 with no inputs asserted -> RUN.
